// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int SA_WIDTH_DEF = 8;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial bit slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock through a single slice.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output Ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_nx;

    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_full;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             slice_sum;
    logic             slice_cout;
    logic             load;
    logic             step;
    logic             last;

    full_adder u_slice (
        .a    (shift_a[0]),
        .b    (shift_b[0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Newest bit enters at the MSB; the oldest WIDTH-1 bits sit in res.
    assign res_full = {slice_sum, res};
    assign busy     = (state == RUN);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last     = 1'b1;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            res     <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            done    <= 1'b0;
            Sum     <= '0;
            Cout    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                shift_a <= A;
                shift_b <= B;
                carry   <= Cin;
                cnt     <= '0;
            end
            if (step) begin
                shift_a <= shift_a >> 1;
                shift_b <= shift_b >> 1;
                res     <= res_full[WIDTH-1:1];
                carry   <= slice_cout;
                cnt     <= cnt + 1'b1;
            end
            if (last) begin
                Sum  <= res_full;
                Cout <= slice_cout;
                done <= 1'b1;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic sign_a;
    logic sign_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            Ovf    <= 1'b0;
        end else begin
            if (load) begin
                sign_a <= A[WIDTH-1];
                sign_b <= B[WIDTH-1];
            end
            if (last) begin
                Ovf <= (sign_a == sign_b) && (slice_sum != sign_a);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       busy;
    logic       done;
    logic [7:0] Sum;
    logic       Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic       Ovf;
`endif

    int checks;
    int errors;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Full transaction: latency, busy width, result, single done pulse.
    task automatic run(input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] es,
                       input logic ec, input logic eo);
        int cyc;
        int bc;
        @(negedge clk);
        start = 1'b1;
        A = a;
        B = b;
        Cin = cin;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        bc = 0;
        while (!done && cyc < 40) begin
            if (busy) bc++;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, 8);
        chk("busy_len", bc, 8);
        chk("sum", {24'h0, Sum}, {24'h0, es});
        chk("cout", {31'h0, Cout}, {31'h0, ec});
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", {31'h0, Ovf}, {31'h0, eo});
`else
        if (eo) begin end
`endif
        @(negedge clk);
        chk("done_pulse", {31'h0, done}, 0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t bb[3];
    int   cyc;
    int   dones;
    logic [7:0] cap_sum;
    logic       cap_cout;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        Cin = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_sum", {24'h0, Sum}, 0);
        chk("rst_cout", {31'h0, Cout}, 0);
        rst = 1'b0;

        run(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        run(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
`endif

        // Start pulsed mid-RUN must be ignored.
        @(negedge clk);
        start = 1'b1;
        A = 8'h33;
        B = 8'h44;
        Cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        A = 8'h01;
        B = 8'h01;
        Cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        cap_sum = '0;
        cap_cout = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                cap_sum = Sum;
                cap_cout = Cout;
            end
        end
        chk("ign_dones", dones, 1);
        chk("ign_sum", {24'h0, cap_sum}, 32'h78);
        chk("ign_cout", {31'h0, cap_cout}, 0);

        // Reset mid-RUN discards the operation.
        @(negedge clk);
        start = 1'b1;
        A = 8'h5A;
        B = 8'h3C;
        Cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_sum", {24'h0, Sum}, 0);
        chk("mid_rst_busy", {31'h0, busy}, 0);
        chk("mid_rst_done", {31'h0, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("post_rst_quiet", dones, 0);
        run(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // Start held high; operands change when each result lands.
        bb[0] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        bb[1] = '{8'h80, 8'h90, 1'b1, 8'h11, 1'b1};
        bb[2] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        @(negedge clk);
        start = 1'b1;
        A = bb[0].a;
        B = bb[0].b;
        Cin = bb[0].c;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            @(negedge clk);
            while (!done && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            chk("b2b_done", {31'h0, done}, 1);
            chk("b2b_sum", {24'h0, Sum}, {24'h0, bb[k].s});
            chk("b2b_cout", {31'h0, Cout}, {31'h0, bb[k].co});
            if (k < 2) begin
                A = bb[k+1].a;
                B = bb[k+1].b;
                Cin = bb[k+1].c;
            end else begin
                start = 1'b0;
            end
        end
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
